// File: rtl/sort_net_pipe.sv
// Pipelined bitonic sorter for N unsigned W-bit keys per vector.
// Each network layer is followed by one register stage, so a vector accepted in cycle c is
// presented on the output in cycle c+S. The whole pipeline advances together and stalls
// together. Every key carries its original input index, so that ties resolve deterministically.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_data             N keys, element i at [i*W +: W]
//   in_desc             0 = ascending, 1 = descending, sampled with the vector
//   out_valid/out_ready output handshake; outputs are held while stalled
//   out_data            sorted keys, element 0 first in sort order
//   out_idx             original input position of each output key, element i at [i*IW +: IW]
//   out_desc            mode the output vector was sorted with
//   occupancy           number of valid vectors in the pipeline, 0..S
module sort_net_pipe #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 4
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [N*W-1:0]                                   in_data,
   input  logic                                             in_desc,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [N*W-1:0]                                   out_data,
   output logic [N*$clog2(N)-1:0]                           out_idx,
   output logic                                             out_desc,
   output logic [$clog2($clog2(N)*($clog2(N)+1)/2+1)-1:0]   occupancy
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned L  = IW;
   localparam int unsigned S  = L * (L + 1) / 2;
   localparam int unsigned OW = $clog2(S + 1);

   logic [W-1:0]  key_q [S][N];
   logic [IW-1:0] idx_q [S][N];
   logic [S-1:0]  desc_q;
   logic [S-1:0]  vld_q;
   logic [OW-1:0] occ_q;

   logic [W-1:0]  key_d [S][N];
   logic [IW-1:0] idx_d [S][N];
   logic [S-1:0]  desc_d;

   logic [W-1:0]  in_key [N];
   logic [IW-1:0] in_tag [N];

   logic adv;
   logic accept;
   logic emit;

   assign adv      = !vld_q[S-1] || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && adv;
   assign emit     = vld_q[S-1] && out_ready;

   for (genvar i = 0; i < N; i++) begin : g_in
      assign in_key[i] = in_data[i*W +: W];
      assign in_tag[i] = IW'(i);
   end

   // Layer St = p*(p-1)/2 + q merges blocks of size K = 2^p with partner distance J.
   // The first layer works on the incoming vector, so stage 0 already holds its result.
   for (genvar p = 1; p <= L; p++) begin : g_blk
      for (genvar q = 0; q < p; q++) begin : g_lyr
         localparam int unsigned St = p * (p - 1) / 2 + q;
         localparam int unsigned K  = 1 << p;
         localparam int unsigned J  = 1 << (p - 1 - q);

         logic [W-1:0]  src_key [N];
         logic [IW-1:0] src_idx [N];
         logic          src_desc;

         if (St == 0) begin : g_src_in
            assign src_key  = in_key;
            assign src_idx  = in_tag;
            assign src_desc = in_desc;
         end else begin : g_src_reg
            assign src_key  = key_q[St-1];
            assign src_idx  = idx_q[St-1];
            assign src_desc = desc_q[St-1];
         end

         assign desc_d[St] = src_desc;

         for (genvar i = 0; i < N; i++) begin : g_el
            if ((i & J) == 0) begin : g_cmp
               localparam int unsigned P  = i + J;
               localparam bit          Up = ((i & K) == 0);

               // Inverting the key in descending mode turns the sort into an ascending sort
               // on {~key, idx}: keys descend while equal keys keep rising index order.
               logic [W+IW-1:0] cx;
               logic [W+IW-1:0] cy;
               logic            swap;

               assign cx   = {src_key[i] ^ {W{src_desc}}, src_idx[i]};
               assign cy   = {src_key[P] ^ {W{src_desc}}, src_idx[P]};
               assign swap = Up ? (cx > cy) : (cx < cy);

               assign key_d[St][i] = swap ? src_key[P] : src_key[i];
               assign key_d[St][P] = swap ? src_key[i] : src_key[P];
               assign idx_d[St][i] = swap ? src_idx[P] : src_idx[i];
               assign idx_d[St][P] = swap ? src_idx[i] : src_idx[P];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         desc_q <= '0;
         occ_q  <= '0;
         for (int s = 0; s < S; s++) begin
            for (int i = 0; i < N; i++) begin
               key_q[s][i] <= '0;
               idx_q[s][i] <= '0;
            end
         end
      end else begin
         if (adv) begin
            vld_q[0] <= accept;
            for (int s = 1; s < S; s++) begin
               vld_q[s] <= vld_q[s-1];
            end
            key_q  <= key_d;
            idx_q  <= idx_d;
            desc_q <= desc_d;
         end
         if (accept && !emit) begin
            occ_q <= occ_q + OW'(1);
         end else if (emit && !accept) begin
            occ_q <= occ_q - OW'(1);
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_out
      assign out_data[i*W +: W]   = key_q[S-1][i];
      assign out_idx[i*IW +: IW]  = idx_q[S-1][i];
   end

   assign out_valid = vld_q[S-1];
   assign out_desc  = desc_q[S-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_sort_net_pipe.sv
// Self-checking bench for sort_net_pipe with N=8, W=4.
module tb_sort_net_pipe;

   localparam int N  = 8;
   localparam int W  = 4;
   localparam int IW = 3;
   localparam int S  = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [N*W-1:0]    in_data = '0;
   logic              in_desc = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [N*W-1:0]    out_data;
   logic [N*IW-1:0]   out_idx;
   logic              out_desc;
   logic [2:0]        occupancy;

   always #5 clk = ~clk;

   sort_net_pipe #(.N(N), .W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_desc   (in_desc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_desc  (out_desc),
      .occupancy (occupancy)
   );

   typedef struct {
      logic [N*W-1:0]  data;
      logic [N*IW-1:0] idx;
      logic            desc;
      int              cyc;
   } sb_t;

   typedef struct {
      logic [N*W-1:0]  din;
      logic            desc;
      logic [N*W-1:0]  exp_d;
      logic [N*IW-1:0] exp_i;
   } vec_t;

   sb_t  q[$];
   vec_t tbl[8];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   emits = 0;
   bit   chk_lat = 1'b1;

   bit              hold_chk = 1'b0;
   logic [N*W-1:0]  hold_d;
   logic [N*IW-1:0] hold_i;
   logic            hold_m;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: stable insertion sort on key; ties keep ascending original index.
   function automatic void model(input logic [N*W-1:0] d, input logic desc,
                                 output logic [N*W-1:0] od, output logic [N*IW-1:0] oi);
      int k[N];
      int x[N];
      int t;
      int j;
      for (int i = 0; i < N; i++) begin
         k[i] = int'(d[i*W +: W]);
         x[i] = i;
      end
      for (int i = 1; i < N; i++) begin
         j = i;
         while (j > 0 && (desc ? (k[j] > k[j-1]) : (k[j] < k[j-1]))) begin
            t = k[j]; k[j] = k[j-1]; k[j-1] = t;
            t = x[j]; x[j] = x[j-1]; x[j-1] = t;
            j--;
         end
      end
      od = '0;
      oi = '0;
      for (int i = 0; i < N; i++) begin
         od[i*W +: W]   = k[i][W-1:0];
         oi[i*IW +: IW] = x[i][IW-1:0];
      end
   endfunction

   // Scoreboard and stall-stability monitor; sampled mid-cycle.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (hold_chk) begin
            check("hold_data", out_data, hold_d);
            check("hold_idx", out_idx, hold_i);
            check("hold_desc", out_desc, hold_m);
         end
         hold_chk = out_valid && !out_ready;
         hold_d = out_data;
         hold_i = out_idx;
         hold_m = out_desc;
         if (out_valid && out_ready) begin
            emits++;
            if (q.size() == 0) begin
               check("spurious_output", 1, 0);
            end else begin
               e = q.pop_front();
               check("sb_data", out_data, e.data);
               check("sb_idx", out_idx, e.idx);
               check("sb_desc", out_desc, e.desc);
               if (chk_lat) check("latency", cyc - e.cyc, S);
            end
         end
         if (in_valid && in_ready) begin
            model(in_data, in_desc, e.data, e.idx);
            e.desc = in_desc;
            e.cyc = cyc;
            q.push_back(e);
         end
      end else begin
         hold_chk = 1'b0;
      end
   end

   task automatic wait_out(output bit ok);
      int c = 0;
      @(negedge clk);
      while (!out_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      ok = out_valid;
   endtask

   task automatic drain(input string nm);
      int c = 0;
      while (q.size() != 0 && c < 100) begin
         @(negedge clk);
         c++;
      end
      check(nm, q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*IW-1:0] ident;
      logic [N*W-1:0]  stream[8];
      bit              ok;
      int              e0;
      int              sent;
      int              ci;
      int              peak;
      bit              stale;

      ident = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      tbl[0] = '{32'h3193F037, 1'b0, 32'hF9733310,
                 {3'd3, 3'd5, 3'd0, 3'd7, 3'd4, 3'd1, 3'd6, 3'd2}};
      tbl[1] = '{32'h3193F037, 1'b1, 32'h0133379F,
                 {3'd2, 3'd6, 3'd7, 3'd4, 3'd1, 3'd0, 3'd5, 3'd3}};
      tbl[2] = '{32'h55555555, 1'b0, 32'h55555555, ident};
      tbl[3] = '{32'h55555555, 1'b1, 32'h55555555, ident};
      tbl[4] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, ident};
      tbl[5] = '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, ident};
      tbl[6] = '{32'h00000000, 1'b0, 32'h00000000, ident};
      tbl[7] = '{32'h00000000, 1'b1, 32'h00000000, ident};

      // Reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single vectors from the table
      for (int t = 0; t < 8; t++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = tbl[t].din;
         in_desc  = tbl[t].desc;
         @(posedge clk); #1;
         in_valid = 1'b0;
         wait_out(ok);
         check($sformatf("tbl%0d_timeout", t), ok, 1);
         if (ok) begin
            check($sformatf("tbl%0d_data", t), out_data, tbl[t].exp_d);
            check($sformatf("tbl%0d_idx", t), out_idx, tbl[t].exp_i);
            check($sformatf("tbl%0d_desc", t), out_desc, tbl[t].desc);
         end
         @(posedge clk); #1;
         check($sformatf("tbl%0d_occ_empty", t), occupancy, 0);
      end
      drain("tbl_drain");

      // Back-to-back random vectors, alternating mode
      e0 = emits;
      for (int v = 0; v < 10; v++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = $urandom;
         in_desc  = (v % 2 == 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain("b2b_drain");
      check("b2b_count", emits - e0, 10);

      // Backpressure: out_ready low for 4 cycles once the pipeline is full
      chk_lat = 1'b0;
      for (int v = 0; v < 8; v++) stream[v] = $urandom;
      e0 = emits;
      sent = 0;
      ci = 0;
      peak = 0;
      while (sent < 8 && ci < 100) begin
         @(posedge clk); #1;
         out_ready = !(ci >= 6 && ci < 10);
         in_valid  = 1'b1;
         in_data   = stream[sent];
         in_desc   = sent[0];
         @(negedge clk);
         if (int'(occupancy) > peak) peak = int'(occupancy);
         if (!out_ready) check("stall_in_ready", in_ready, 0);
         if (in_ready) sent++;
         ci++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_sent", sent, 8);
      drain("bp_drain");
      check("bp_count", emits - e0, 8);
      check("bp_peak_occ", peak, S);
      check("bp_occ_empty", occupancy, 0);
      chk_lat = 1'b1;

      // Reset with vectors in flight
      for (int v = 0; v < 3; v++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = $urandom;
         in_desc  = v[0];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_occupancy", occupancy, 0);
      q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check("midrst_stale", stale, 0);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = tbl[0].din;
      in_desc  = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(ok);
      check("postrst_timeout", ok, 1);
      if (ok) check("postrst_data", out_data, tbl[0].exp_d);
      drain("postrst_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
